decode_stage: RTL
=================

Name: decode_stage

Overview:
- Registered RV32I/RV64I decode stage between fetch (imem) and the register-file/execute stage.
- Takes one instruction word plus its PC per accepted transfer and produces the full control bundle, immediate, register indices and an illegal flag.
- Uses valid/ready handshakes on both sides, with an optional 2-entry skid buffer so backpressure does not create a combinational path to fetch.
- Successor to the single-cycle combinational decoder: it is width-parametrised, covers every base opcode, and adds pipelining, flush and illegal detection.

Parameters:
- XLEN, 32, datapath width. Legal values: 32 or 64. Sets the width of immediate and pc.
- DEPTH, 2, output buffering. 1 = single pipeline register. 2 = skid buffer (main + skid entry).

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  discard all buffered entries (branch redirect)
- in_valid  in  1  fetch has an instruction
- in_ready  out  1  stage can accept this cycle
- in_instr  in  32  instruction word
- in_pc  in  XLEN  instruction PC
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  downstream accepts
- out_pc  out  XLEN  PC of decoded instruction
- out_branch, out_jump, out_mem_read, out_memtoreg, out_mem_write, out_alu_src, out_write_enable  out  1 each  control signals
- out_alu_op  out  2  00 add, 01 branch compare, 10 R-type funct, 11 I-type ALU funct
- out_jalr  out  1  jump target is rs1+imm
- out_pc_src  out  1  ALU operand A = PC (AUIPC, JAL)
- out_mul_div  out  1  M-extension op
- out_immediate  out  XLEN  sign-extended immediate
- out_rd, out_rs1, out_rs2  out  5 each  register indices
- out_funct3  out  3  instr[14:12]
- out_illegal  out  1  unsupported encoding

Behaviour:
- Reset (async on rst_n low):
  - out_valid=0; all out_* fields=0.
  - DEPTH=1: in_ready=1. DEPTH=2: in_ready=1, skid empty.
  - Reset mid-transfer drops the instruction silently.
- Decode (combinational from in_instr, registered on accept):
  - LOAD 0000011: alu_src, memtoreg, mem_read, write_enable; I-immediate.
  - OP-IMM 0010011: alu_src, write_enable, alu_op=11; I-immediate.
  - STORE 0100011: alu_src, mem_write; S-immediate. write_enable=0.
  - BRANCH 1100011: branch, alu_op=01; B-immediate (bit0=0).
  - LUI 0110111: alu_src, write_enable; U-immediate (operand A forced zero by execute).
  - AUIPC 0010111: alu_src, pc_src, write_enable; U-immediate.
  - JAL 1101111: jump, pc_src, write_enable; J-immediate.
  - JALR 1100111: jump, jalr, alu_src, write_enable; I-immediate.
  - OP 0110011: write_enable, alu_op=10. funct7 must be 0000000, or 0100000 only with funct3 000/101; otherwise illegal.
  - FENCE 0001111 and SYSTEM 1110011: all controls 0; not illegal (NOP).
  - Anything else, or instr[1:0]!=11: illegal=1, all controls and immediate 0. rd/rs fields still forwarded.
  - Immediates sign-extend from instr[31] to XLEN; U-immediate also sign-extends above bit 31 when XLEN=64.
- Handshake:
  - Transfer on in_valid&&in_ready (input side) and out_valid&&out_ready (output side).
  - out_* are stable while out_valid&&!out_ready.
- DEPTH=1:
  - in_ready = !out_valid || out_ready (combinational).
  - Latency 1 cycle; throughput 1/cycle.
- DEPTH=2:
  - in_ready is a registered signal = skid empty.
  - If the main entry is stalled and an input is accepted, the decoded input goes to skid.
  - When the main entry drains, skid moves to main the same cycle.
  - Full = main+skid both valid; in_ready=0.
  - Latency 1 cycle; throughput 1/cycle under continuous ready.
- flush:
  - Next edge: out_valid=0, skid emptied, in_ready=1.
  - flush wins over a simultaneous input accept; that instruction is dropped.
  - flush has no effect on output fields other than out_valid.

Optional Feature:
- Macro: DECODE_RVM_EN.
- Defined: OP with funct7=0000001 is legal; sets write_enable, alu_op=10, mul_div=1.
- Undefined: funct7=0000001 on OP is illegal; out_mul_div is tied 0.

Decomposition:
- Package decode_pkg holds:
  - opcode constants: OPC_LOAD, OPC_OP_IMM, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_OP, OPC_FENCE, OPC_SYSTEM
  - ALU_OP_* encodings
  - packed struct ctrl_t for the control bundle
- Sub-module decode_comb: pure combinational instruction -> ctrl_t + immediate, parametrised on XLEN.
- decode_stage instantiates decode_comb and owns the handshake/skid registers.

Test Plan:
- 0x00500093 (addi x1,x0,5), out_ready=1 -> next cycle: out_valid=1, alu_op=11, alu_src=1, write_enable=1, imm=5, rd=1.
- 0xFE000EE3 (beq x0,x0,-4) -> branch=1, alu_op=01, imm=0xFFFFFFFC (XLEN=32) / 0xFFFFFFFFFFFFFFFC (XLEN=64).
- Back-to-back 0x0080A103 (lw x2,8(x1)), 0x0020A623 (sw x2,12(x1)), out_ready=0 for 3 cycles, DEPTH=2 -> in_ready drops after 2nd accept; lw then sw emerge in order, no loss or duplication.
- 0x022081B3 (mul x3,x1,x2) -> with DECODE_RVM_EN: mul_div=1, illegal=0; without: illegal=1, write_enable=0.
- 0xFFFFFFFF -> illegal=1, all controls 0, imm=0.
- Two entries buffered, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1; the flushed-cycle instruction never appears.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared opcode constants, ALU-op encodings and bundle types for the decode stage.
package decode_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [1:0] ALU_OP_ADD    = 2'b00;
    localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
    localparam logic [1:0] ALU_OP_RTYPE  = 2'b10;
    localparam logic [1:0] ALU_OP_ITYPE  = 2'b11;

    typedef struct packed {
        logic       branch;
        logic       jump;
        logic       mem_read;
        logic       memtoreg;
        logic       mem_write;
        logic       alu_src;
        logic       write_enable;
        logic [1:0] alu_op;
        logic       jalr;
        logic       pc_src;
        logic       mul_div;
        logic       illegal;
    } ctrl_t;

    // Width-independent part of a buffered entry; pc and immediate live beside it.
    typedef struct packed {
        ctrl_t      ctrl;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [2:0] funct3;
    } entry_t;

endpackage

// File: rtl/decode_comb.sv
// Combinational RV32I/RV64I instruction decoder: control bundle plus sign-extended immediate.
// DECODE_RVM_EN: when defined, OP with funct7=0000001 decodes as an M-extension op.
module decode_comb
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output ctrl_t           ctrl,
    output logic [XLEN-1:0] immediate
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] imm32;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    always_comb begin
        ctrl  = '0;
        imm32 = '0;
        case (opcode)
            OPC_LOAD: begin
                ctrl.alu_src      = 1'b1;
                ctrl.memtoreg     = 1'b1;
                ctrl.mem_read     = 1'b1;
                ctrl.write_enable = 1'b1;
                imm32             = imm_i;
            end
            OPC_OP_IMM: begin
                ctrl.alu_src      = 1'b1;
                ctrl.write_enable = 1'b1;
                ctrl.alu_op       = ALU_OP_ITYPE;
                imm32             = imm_i;
            end
            OPC_STORE: begin
                ctrl.alu_src   = 1'b1;
                ctrl.mem_write = 1'b1;
                imm32          = imm_s;
            end
            OPC_BRANCH: begin
                ctrl.branch = 1'b1;
                ctrl.alu_op = ALU_OP_BRANCH;
                imm32       = imm_b;
            end
            OPC_LUI: begin
                ctrl.alu_src      = 1'b1;
                ctrl.write_enable = 1'b1;
                imm32             = imm_u;
            end
            OPC_AUIPC: begin
                ctrl.alu_src      = 1'b1;
                ctrl.pc_src       = 1'b1;
                ctrl.write_enable = 1'b1;
                imm32             = imm_u;
            end
            OPC_JAL: begin
                ctrl.jump         = 1'b1;
                ctrl.pc_src       = 1'b1;
                ctrl.write_enable = 1'b1;
                imm32             = imm_j;
            end
            OPC_JALR: begin
                ctrl.jump         = 1'b1;
                ctrl.jalr         = 1'b1;
                ctrl.alu_src      = 1'b1;
                ctrl.write_enable = 1'b1;
                imm32             = imm_i;
            end
            OPC_OP: begin
                // Only ADD/SUB and SRL/SRA use the alternate funct7 encoding.
                if (funct7 == 7'b0000000 ||
                    (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))) begin
                    ctrl.write_enable = 1'b1;
                    ctrl.alu_op       = ALU_OP_RTYPE;
                end
`ifdef DECODE_RVM_EN
                else if (funct7 == 7'b0000001) begin
                    ctrl.write_enable = 1'b1;
                    ctrl.alu_op       = ALU_OP_RTYPE;
                    ctrl.mul_div      = 1'b1;
                end
`endif
                else begin
                    ctrl.illegal = 1'b1;
                end
            end
            OPC_FENCE, OPC_SYSTEM: begin
                ctrl = '0;
            end
            default: begin
                ctrl.illegal = 1'b1;
            end
        endcase
    end

    assign immediate = XLEN'($signed(imm32));

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage with valid/ready on both sides; DEPTH=2 adds a skid entry so
// in_ready comes straight from a flop. DECODE_RVM_EN (see decode_comb) enables M-extension decode.
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic            out_branch,
    output logic            out_jump,
    output logic            out_mem_read,
    output logic            out_memtoreg,
    output logic            out_mem_write,
    output logic            out_alu_src,
    output logic            out_write_enable,
    output logic [1:0]      out_alu_op,
    output logic            out_jalr,
    output logic            out_pc_src,
    output logic            out_mul_div,
    output logic [XLEN-1:0] out_immediate,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [2:0]      out_funct3,
    output logic            out_illegal
);

    ctrl_t           dec_ctrl;
    logic [XLEN-1:0] dec_imm;
    entry_t          dec_ent;

    logic            main_valid;
    entry_t          main_ent;
    logic [XLEN-1:0] main_pc;
    logic [XLEN-1:0] main_imm;
    logic            accept;

    decode_comb #(.XLEN(XLEN)) u_decode_comb (
        .instr     (in_instr),
        .ctrl      (dec_ctrl),
        .immediate (dec_imm)
    );

    assign dec_ent = {dec_ctrl, in_instr[11:7], in_instr[19:15], in_instr[24:20], in_instr[14:12]};
    assign accept  = in_valid && in_ready;

    generate
        if (DEPTH == 1) begin : g_single
            assign in_ready = !main_valid || out_ready;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    main_valid <= 1'b0;
                    main_ent   <= '0;
                    main_pc    <= '0;
                    main_imm   <= '0;
                end else if (flush) begin
                    main_valid <= 1'b0;
                end else if (accept) begin
                    main_valid <= 1'b1;
                    main_ent   <= dec_ent;
                    main_pc    <= in_pc;
                    main_imm   <= dec_imm;
                end else if (out_ready) begin
                    main_valid <= 1'b0;
                end
            end
        end else begin : g_skid
            logic            skid_valid;
            entry_t          skid_ent;
            logic [XLEN-1:0] skid_pc;
            logic [XLEN-1:0] skid_imm;

            // Skid can only hold data while it is occupied, so in_ready is just its empty flag.
            assign in_ready = !skid_valid;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    main_valid <= 1'b0;
                    main_ent   <= '0;
                    main_pc    <= '0;
                    main_imm   <= '0;
                    skid_valid <= 1'b0;
                    skid_ent   <= '0;
                    skid_pc    <= '0;
                    skid_imm   <= '0;
                end else if (flush) begin
                    main_valid <= 1'b0;
                    skid_valid <= 1'b0;
                end else if (!main_valid || out_ready) begin
                    if (skid_valid) begin
                        main_valid <= 1'b1;
                        main_ent   <= skid_ent;
                        main_pc    <= skid_pc;
                        main_imm   <= skid_imm;
                        skid_valid <= 1'b0;
                    end else if (accept) begin
                        main_valid <= 1'b1;
                        main_ent   <= dec_ent;
                        main_pc    <= in_pc;
                        main_imm   <= dec_imm;
                    end else begin
                        main_valid <= 1'b0;
                    end
                end else if (accept) begin
                    skid_valid <= 1'b1;
                    skid_ent   <= dec_ent;
                    skid_pc    <= in_pc;
                    skid_imm   <= dec_imm;
                end
            end
        end
    endgenerate

    assign out_valid        = main_valid;
    assign out_pc           = main_pc;
    assign out_immediate    = main_imm;
    assign out_branch       = main_ent.ctrl.branch;
    assign out_jump         = main_ent.ctrl.jump;
    assign out_mem_read     = main_ent.ctrl.mem_read;
    assign out_memtoreg     = main_ent.ctrl.memtoreg;
    assign out_mem_write    = main_ent.ctrl.mem_write;
    assign out_alu_src      = main_ent.ctrl.alu_src;
    assign out_write_enable = main_ent.ctrl.write_enable;
    assign out_alu_op       = main_ent.ctrl.alu_op;
    assign out_jalr         = main_ent.ctrl.jalr;
    assign out_pc_src       = main_ent.ctrl.pc_src;
    assign out_mul_div      = main_ent.ctrl.mul_div;
    assign out_illegal      = main_ent.ctrl.illegal;
    assign out_rd           = main_ent.rd;
    assign out_rs1          = main_ent.rs1;
    assign out_rs2          = main_ent.rs2;
    assign out_funct3       = main_ent.funct3;

endmodule
